// File: rtl/aes_enc_sequencer.sv
// Iterative AES-128 encryptor: one round per cycle, result valid 10 cycles after input handshake.
// Single block in flight; in_ready only in IDLE, ciphertext held until out_ready.
module aes_enc_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int RC_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_pt,
  input  logic [127:0]    in_key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_ct,
  output logic            busy,
  output logic [RC_W-1:0] round_idx
);

  if (NUM_ROUNDS != 10) begin : g_bad_num_rounds
    $error("aes_enc_sequencer supports NUM_ROUNDS == 10 only");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_LAST, S_DONE} fsm_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] i);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox(i[8*k +: 8]);
    return o;
  endfunction

  // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] i);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = i[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] i);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = i[127-32*c -: 8];
      a1 = i[119-32*c -: 8];
      a2 = i[111-32*c -: 8];
      a3 = i[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon(input logic [RC_W-1:0] idx);
    case (int'(idx))
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  fsm_e            fsm_q, fsm_d;
  logic [127:0]    blk_q, blk_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    ct_q, ct_d;
  logic [RC_W-1:0] round_q, round_d;
  logic [127:0]    key_next;
  logic [127:0]    sr_blk;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      blk_q   <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (in_valid) fsm_d = S_ROUND;
      S_ROUND: if (round_q == RC_W'(NUM_ROUNDS - 1)) fsm_d = S_LAST;
      S_LAST:  fsm_d = S_DONE;
      S_DONE:  if (out_ready) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (fsm_q == S_IDLE);
    out_valid = (fsm_q == S_DONE);
    busy      = (fsm_q != S_IDLE);
    out_ct    = ct_q;
    round_idx = round_q;
  end

  // Key expansion runs every cycle off the current round index; only ROUND/LAST consume it.
  assign key_next = key_expand(key_q, rcon(round_q));
  assign sr_blk   = shift_rows(sub_bytes(blk_q));

  always_comb begin
    blk_d   = blk_q;
    key_d   = key_q;
    ct_d    = ct_q;
    round_d = round_q;
    case (fsm_q)
      S_IDLE: if (in_valid) begin
        blk_d   = in_pt ^ in_key;
        key_d   = in_key;
        round_d = RC_W'(1);
      end
      S_ROUND: begin
        blk_d   = mix_columns(sr_blk) ^ key_next;
        key_d   = key_next;
        round_d = round_q + RC_W'(1);
      end
      S_LAST:  ct_d = sr_blk ^ key_next;
      S_DONE:  if (out_ready) round_d = '0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_enc_sequencer.sv
// Randomized bench for aes_enc_sequencer against a byte-array AES-128 model using GF(2^8) arithmetic.
module tb_aes_enc_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_pt = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_ct;
  logic         busy;
  logic [3:0]   round_idx;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [256];

  aes_enc_sequencer #(.NUM_ROUNDS(10), .RC_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct),
    .busy(busy), .round_idx(round_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (!rst) begin
      assert (round_idx <= 4'd10) else begin
        errors++;
        $display("FAIL round_idx_range: got %0d, required <= 10", round_idx);
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   k [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      t[0] = k[0] ^ sb[k[13]] ^ rc;
      t[1] = k[1] ^ sb[k[14]];
      t[2] = k[2] ^ sb[k[15]];
      t[3] = k[3] ^ sb[k[12]];
      for (int i = 4; i < 16; i++) t[i] = k[i] ^ t[i-4];
      for (int i = 0; i < 16; i++) k[i] = t[i];
      rc = gmul(rc, 8'h02);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[rr+4*c] = sb[s[rr+4*((c+rr)%4)]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          if (r < 10)
            s[rr+4*c] = gmul(8'h02, t[rr+4*c]) ^ gmul(8'h03, t[(rr+1)%4+4*c])
                      ^ t[(rr+2)%4+4*c] ^ t[(rr+3)%4+4*c];
          else
            s[rr+4*c] = t[rr+4*c];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic run_vec(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp,
                         input int hold, input bit chk_r1, input logic [127:0] r1);
    int lat;
    in_pt = pt;
    in_key = key;
    in_valid = 1'b1;
    out_ready = 1'b0;
    check("in_ready_idle", in_ready, 1);
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      check("round_idx_seq", round_idx, lat + 1);
      check("busy_run", busy, 1);
      if (chk_r1 && lat == 1) check("round1_state", dut.blk_q, r1);
      in_pt = rnd128();
      in_key = rnd128();
      tick;
      lat++;
    end
    check("latency", lat, 10);
    check("ciphertext", out_ct, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      check("in_ready_hold", in_ready, 0);
      check("valid_hold", out_valid, 1);
      check("ct_hold", out_ct, exp);
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
    check("round_idx_after_hs", round_idx, 0);
    check("busy_after_hs", busy, 0);
  endtask

  task automatic back_to_back;
    logic [127:0] p [2];
    logic [127:0] k [2];
    logic [127:0] got [$];
    int hs [2];
    int n_in;
    int cyc;
    for (int i = 0; i < 2; i++) begin
      p[i] = rnd128();
      k[i] = rnd128();
      hs[i] = 0;
    end
    n_in = 0;
    cyc = 0;
    in_pt = p[0];
    in_key = k[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    while ((n_in < 2 || got.size() < 2) && cyc < 60) begin
      if (out_valid) got.push_back(out_ct);
      if (in_valid && in_ready) begin
        hs[n_in] = cyc;
        n_in++;
      end
      tick;
      cyc++;
      if (n_in < 2) begin
        in_pt = p[n_in];
        in_key = k[n_in];
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    check("b2b_accepts", n_in, 2);
    check("b2b_spacing", hs[1] - hs[0], 12);
    check("b2b_results", got.size(), 2);
    if (got.size() >= 2) begin
      check("b2b_ct0", got[0], aes_ref(p[0], k[0]));
      check("b2b_ct1", got[1], aes_ref(p[1], k[1]));
    end
  endtask

  task automatic mid_reset;
    int n;
    int spurious;
    in_pt = rnd128();
    in_key = rnd128();
    in_valid = 1'b1;
    check("in_ready_pre_rst", in_ready, 1);
    tick;
    in_valid = 1'b0;
    n = 0;
    while (round_idx != 4'd5 && n < 20) begin
      tick;
      n++;
    end
    check("reach_round5", round_idx, 5);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_out_ct", out_ct, 0);
    check("rst_busy", busy, 0);
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) spurious++;
      tick;
    end
    check("no_spurious_valid", spurious, 0);
  endtask

  initial begin
    logic [127:0] pt, key;
    build_sbox();
    rst = 1'b1;
    tick;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_ct", out_ct, 0);
    check("reset_busy", busy, 0);
    check("reset_round_idx", round_idx, 0);
    tick;
    rst = 1'b0;

    run_vec(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0, 128'h0);
    run_vec(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
            128'h3925841d02dc09fbdc118597196a0b32, 3, 1'b1, 128'ha49c7ff2689f352b6b5bea43026a5049);

    pt = rnd128();
    key = rnd128();
    run_vec(pt, key, aes_ref(pt, key), 20, 1'b0, 128'h0);

    back_to_back();
    mid_reset();

    for (int v = 0; v < 5; v++) begin
      pt = rnd128();
      key = rnd128();
      run_vec(pt, key, aes_ref(pt, key), $urandom_range(0, 3), 1'b0, 128'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_enc_sequencer.md
Name: aes_enc_sequencer

Overview:
- Iterative AES-128 encryption controller. Owns the state and round-key registers and sequences the team's one-round-per-cycle datapath.
- Datapath stages:
  - Initial AddRoundKey.
  - Nine full rounds: SubBytes, ShiftRows, MixColumns, AddRoundKey, plus the key expansion step.
  - One final round with no MixColumns.
- Sits between the core-side AES register interface (upstream) and the result FIFO (downstream).
- Ready/valid handshake on both sides, so a block is never lost under backpressure.

Parameters:
- NUM_ROUNDS, 10, total rounds including the final round. Only 10 is supported; any other value is a compile-time error.
- RC_W, 4, width of the round-constant index driven to the key-expansion step.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext/key pair offered.
- in_ready  output  1  sequencer can accept a pair.
- in_pt  input  128  plaintext, byte 0 in bits [127:120].
- in_key  input  128  cipher key, same byte order as in_pt.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  downstream accepts ciphertext.
- out_ct  output  128  ciphertext.
- busy  output  1  high in ROUND, LAST and DONE.
- round_idx  output  RC_W  current round number, 0 when idle; debug and key-expansion rc.

Behaviour:
- Reset values (on rst sampled high at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0, out_ct=0, busy=0, round_idx=0.
  - State and key registers are cleared to 0.
  - rst overrides every other input.
  - Reset mid-operation discards the block in flight. No out_valid follows.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_reg<=in_pt^in_key, key_reg<=in_key, round_idx<=1, go to ROUND.
- ROUND (round_idx 1..9), one round per cycle:
  - key_next=KeyExpand(key_reg, rc=round_idx).
  - state_reg<=MixColumns(ShiftRows(SubBytes(state_reg)))^key_next.
  - key_reg<=key_next.
  - round_idx increments each cycle.
  - Leaving round 9: round_idx<=10, go to LAST.
- LAST (round_idx=10):
  - out_ct<=ShiftRows(SubBytes(state_reg))^KeyExpand(key_reg, rc=10).
  - out_valid<=1, go to DONE.
- DONE:
  - out_valid=1. out_ct is held stable until out_valid&&out_ready.
  - On handshake: out_valid<=0, round_idx<=0, go to IDLE.
- in_ready=1 only in IDLE. There is no overlap: new input is not accepted while a result is pending.
- Latency: input handshake at edge N gives out_valid high after edge N+10, i.e. visible in cycle N+10.
  - With out_ready held high, throughput is one block per 12 cycles: accept, 9 rounds, last, drain.
- in_pt/in_key are sampled only on the handshake edge. Changes at other times have no effect.
- out_ready asserted while out_valid=0 is ignored.
- in_valid may drop without a handshake; no state change results.
- Round constants, indexed by round_idx 1..10: 01,02,04,08,10,20,40,80,1b,36.
  - round_idx is RC_W bits and never exceeds 10. Wrap past 10 is a design error; the bench checks it by assertion.
- S-box, MixColumns and key expansion reuse the team's existing combinational functions. No additional pipeline registers.

Test Plan:
- FIPS-197 App. C.1:
  - key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Requires out_ct=69c4e0d86a7b0430d8cdb78070b4c55a.
  - out_valid rises exactly 10 cycles after the input handshake.
- FIPS-197 App. B:
  - key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Requires out_ct=3925841d02dc09fbdc118597196a0b32.
  - Internal state after round 1 is a49c7ff2689f352b6b5bea43026a5049.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid.
  - out_ct stays stable, in_ready stays 0, and in_valid pulses are ignored.
  - Raising out_ready completes exactly one handshake, then in_ready=1 the next cycle.
- Back-to-back: two vectors with out_ready=1 and in_valid continuously high.
  - Second handshake occurs 12 cycles after the first.
  - Both ciphertexts are correct and in order.
- Reset mid-operation:
  - Assert rst at round_idx=5.
  - Next cycle: in_ready=1, out_valid=0, round_idx=0.
  - No spurious out_valid in the following 15 cycles.
  - A new vector then encrypts correctly.
- Input stability: change in_pt/in_key every cycle after the handshake. Ciphertext still matches the sampled pair.
